// File: rtl/count_down_timer_pkg.sv
// rtl/count_down_timer_pkg.sv - shared state encoding and mode constants for count_down_timer
package count_down_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/count_down_timer_prescale_tick.sv
// rtl/count_down_timer_prescale_tick.sv - clock prescaler producing one count tick every PRESCALE enabled cycles
module prescale_tick #(
    parameter int PRESCALE = 1
) (
    input  logic clk_250,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_ok;
            assign unused_ok = clk_250 ^ rst ^ clr;
            assign tick      = en;
        end else begin : g_count
            localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
            logic [CW-1:0] phase;

            assign tick = en && (phase == LAST);

            // phase is kept while disabled so a paused timer resumes mid-period
            always_ff @(posedge clk_250 or negedge rst) begin
                if (!rst) begin
                    phase <= '0;
                end else if (clr) begin
                    phase <= '0;
                end else if (en) begin
                    phase <= tick ? '0 : phase + CW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/count_down_timer.sv
// rtl/count_down_timer.sv - programmable down-counter timer with prescaler, one-shot and auto-reload
module count_down_timer
    import count_down_timer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int INIT_VAL = 3
) (
    input  logic             clk_250,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             timer_flag,
    output logic             tc_pulse
);

    localparam logic [WIDTH-1:0] INIT = WIDTH'(INIT_VAL);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] reload_reg, reload_n, count_n;
    logic             tc_n, clr, tick, go;

    assign go = start & ~stop;

    prescale_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk_250 (clk_250),
        .rst     (rst),
        .en      (state == ST_RUN),
        .clr     (clr),
        .tick    (tick)
    );

    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_reg;
        tc_n     = 1'b0;
        clr      = 1'b0;
        if (load) begin
            count_n  = load_val;
            reload_n = load_val;
            clr      = 1'b1;
            // a zero load can never reach a terminal tick, so it parks in IDLE
            state_n  = ((load_val != '0) && (go || state == ST_RUN)) ? ST_RUN : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        clr = 1'b1;
                        if (count != '0) begin
                            state_n = ST_RUN;
                        end else begin
                            state_n = ST_DONE;
                            tc_n    = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_n = ST_HOLD;
                    end else if (tick) begin
                        if (count > ONE) begin
                            count_n = count - ONE;
                        end else if (mode == MODE_RELOAD && reload_reg != '0) begin
                            count_n = reload_reg;
                            tc_n    = 1'b1;
                        end else begin
                            count_n = '0;
                            state_n = ST_DONE;
                            tc_n    = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (go) begin
                        state_n = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (go && reload_reg != '0) begin
                        clr     = 1'b1;
                        count_n = reload_reg;
                        state_n = ST_RUN;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_250 or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            count      <= INIT;
            reload_reg <= INIT;
            busy       <= 1'b0;
            timer_flag <= 1'b0;
            tc_pulse   <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_reg <= reload_n;
            busy       <= (state_n == ST_RUN);
            timer_flag <= (state_n == ST_DONE);
            tc_pulse   <= tc_n;
        end
    end

endmodule

// File: tb/tb_count_down_timer.sv
// tb/tb_count_down_timer.sv - self-checking bench for count_down_timer at PRESCALE 1 and 4
module tb_count_down_timer;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    logic       clk_250 = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] count1, count4;
    logic       busy1, busy4, flag1, flag4, tc1, tc4;

    int checks = 0;
    int errors = 0;

    int m_cnt [2];
    int m_rel [2];
    int m_ph  [2];
    int m_st  [2];
    int m_tc  [2];

    always #5 clk_250 = ~clk_250;

    count_down_timer #(.WIDTH(8), .PRESCALE(1), .INIT_VAL(3)) u_dut1 (
        .clk_250 (clk_250), .rst (rst), .load (load), .load_val (load_val),
        .start (start), .stop (stop), .mode (mode), .count (count1),
        .busy (busy1), .timer_flag (flag1), .tc_pulse (tc1)
    );

    count_down_timer #(.WIDTH(8), .PRESCALE(4), .INIT_VAL(3)) u_dut4 (
        .clk_250 (clk_250), .rst (rst), .load (load), .load_val (load_val),
        .start (start), .stop (stop), .mode (mode), .count (count4),
        .busy (busy4), .timer_flag (flag4), .tc_pulse (tc4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 3; m_rel[i] = 3; m_ph[i] = 0; m_st[i] = M_IDLE; m_tc[i] = 0;
        end
    endtask

    // timer behaviour in terms of ticks elapsed: phase counts enabled cycles modulo ps
    task automatic model_step(input int i, input int ps, input bit ld, input int lv,
                              input bit st, input bit sp, input bit md);
        bit go, tk;
        go = st && !sp;
        m_tc[i] = 0;
        if (ld) begin
            m_cnt[i] = lv; m_rel[i] = lv; m_ph[i] = 0;
            m_st[i] = (lv != 0 && (go || m_st[i] == M_RUN)) ? M_RUN : M_IDLE;
        end else if (m_st[i] == M_IDLE) begin
            if (go) begin
                m_ph[i] = 0;
                if (m_cnt[i] != 0) m_st[i] = M_RUN;
                else begin m_st[i] = M_DONE; m_tc[i] = 1; end
            end
        end else if (m_st[i] == M_RUN) begin
            m_ph[i] = (m_ph[i] + 1) % ps;
            tk = (m_ph[i] == 0);
            if (sp) m_st[i] = M_HOLD;
            else if (tk) begin
                if (m_cnt[i] >= 2) m_cnt[i] = m_cnt[i] - 1;
                else if (md && m_rel[i] != 0) begin m_cnt[i] = m_rel[i]; m_tc[i] = 1; end
                else begin m_cnt[i] = 0; m_st[i] = M_DONE; m_tc[i] = 1; end
            end
        end else if (m_st[i] == M_HOLD) begin
            if (go) m_st[i] = M_RUN;
        end else begin
            if (go && m_rel[i] != 0) begin m_ph[i] = 0; m_cnt[i] = m_rel[i]; m_st[i] = M_RUN; end
        end
    endtask

    task automatic compare_model();
        chk("cnt1", count1, m_cnt[0]);
        chk("busy1", busy1, m_st[0] == M_RUN);
        chk("flag1", flag1, m_st[0] == M_DONE);
        chk("tc1", tc1, m_tc[0]);
        chk("cnt4", count4, m_cnt[1]);
        chk("busy4", busy4, m_st[1] == M_RUN);
        chk("flag4", flag4, m_st[1] == M_DONE);
        chk("tc4", tc4, m_tc[1]);
    endtask

    task automatic cyc(input bit ld, input int lv, input bit st, input bit sp);
        @(negedge clk_250);
        load = ld; load_val = lv[7:0]; start = st; stop = sp;
        @(posedge clk_250);
        if (rst) begin
            model_step(0, 1, ld, lv, st, sp, mode);
            model_step(1, 4, ld, lv, st, sp, mode);
        end else begin
            model_reset();
        end
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk_250);
        rst = 1'b0; load = 0; start = 0; stop = 0;
        model_reset();
        @(negedge clk_250);
        rst = 1'b1;
    endtask

    initial begin
        int first_tc, n_tc, flag_seen, run_n, k;
        bit r_ld, r_st, r_sp;
        int r_lv;

        model_reset();
        repeat (3) @(negedge clk_250);
        chk("rst_cnt", count1, 3);
        chk("rst_busy", busy1, 0);
        chk("rst_flag", flag1, 0);
        chk("rst_tc", tc4, 0);
        rst = 1'b1;

        // default one-shot from INIT_VAL on the PRESCALE=1 instance
        cyc(0, 0, 1, 0);
        chk("a_start_cnt", count1, 3);
        chk("a_start_busy", busy1, 1);
        cyc(0, 0, 0, 0); chk("a_cnt2", count1, 2);
        cyc(0, 0, 0, 0); chk("a_cnt1", count1, 1);
        cyc(0, 0, 0, 0);
        chk("a_cnt0", count1, 0); chk("a_tc", tc1, 1);
        chk("a_flag", flag1, 1); chk("a_busy", busy1, 0);
        cyc(0, 0, 0, 0);
        chk("a_tc_once", tc1, 0); chk("a_flag_hold", flag1, 1);

        // auto-reload period on the PRESCALE=4 instance
        do_reset();
        mode = 1'b1;
        cyc(1, 5, 1, 0);
        first_tc = 0; n_tc = 0; flag_seen = 0;
        for (int j = 1; j <= 45; j++) begin
            cyc(0, 0, 0, 0);
            if (tc4 && j <= 40) begin
                n_tc++;
                if (first_tc == 0) first_tc = j;
            end
            if (flag4) flag_seen = 1;
        end
        chk("b_first_tc", first_tc, 20);
        chk("b_num_tc", n_tc, 2);
        chk("b_no_flag", flag_seen, 0);

        // dropping to one-shot before the next terminal tick ends in DONE
        mode = 1'b0;
        k = 0;
        while (!flag4 && k < 100) begin cyc(0, 0, 0, 0); k++; end
        chk("m_flag", flag4, 1);
        chk("m_cnt", count4, 0);
        chk("m_tc", tc4, 1);

        // pause and resume keeps prescaler phase
        do_reset();
        cyc(1, 10, 0, 0);
        cyc(0, 0, 1, 0);
        run_n = busy4;
        for (int j = 0; j < 8; j++) begin cyc(0, 0, 0, 0); run_n += busy4; end
        cyc(0, 0, 0, 1);
        chk("c_stop_cnt", count4, 8);
        repeat (50) cyc(0, 0, 0, 0);
        chk("c_hold_cnt", count4, 8);
        chk("c_hold_busy", busy4, 0);
        cyc(0, 0, 1, 0); run_n += busy4;
        cyc(0, 0, 0, 0); run_n += busy4;
        cyc(0, 0, 0, 0); run_n += busy4;
        chk("c_pre_dec", count4, 8);
        cyc(0, 0, 0, 0); run_n += busy4;
        chk("c_resume_dec", count4, 7);
        k = 0;
        while (!flag4 && k < 100) begin cyc(0, 0, 0, 0); run_n += busy4; k++; end
        chk("c_done", flag4, 1);
        chk("c_run_cycles", run_n, 40);

        // collisions
        do_reset();
        cyc(1, 7, 1, 0);
        chk("d_loadgo_cnt", count4, 7); chk("d_loadgo_busy", busy4, 1);
        cyc(0, 0, 1, 1);
        chk("d_stopwins", busy4, 0);
        cyc(0, 0, 1, 0);
        k = 0;
        while (count4 != 8'd2 && k < 60) begin cyc(0, 0, 0, 0); k++; end
        chk("d_reach2", count4, 2);
        cyc(1, 7, 0, 0);
        chk("d_reload_cnt", count4, 7); chk("d_reload_busy", busy4, 1);
        repeat (3) cyc(0, 0, 0, 0);
        chk("d_restart_hold", count4, 7);
        cyc(0, 0, 0, 0);
        chk("d_restart_dec", count4, 6);
        do_reset();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("d_zero_tc", tc1, 1); chk("d_zero_flag", flag1, 1);
        chk("d_zero_cnt", count4, 0); chk("d_zero_busy", busy4, 0);
        cyc(0, 0, 0, 0);
        chk("d_zero_tc_once", tc4, 0);

        // asynchronous reset between edges
        do_reset();
        cyc(1, 6, 1, 0);
        k = 0;
        while (count4 != 8'd4 && k < 40) begin cyc(0, 0, 0, 0); k++; end
        chk("e_reach4", count4, 4);
        #2 rst = 1'b0;
        #1;
        chk("e_async_cnt", count4, 3);
        chk("e_async_busy", busy4, 0);
        chk("e_async_tc", tc4, 0);
        chk("e_async_cnt1", count1, 3);
        model_reset();
        cyc(0, 0, 0, 0);
        @(negedge clk_250) rst = 1'b1;
        flag_seen = 0;
        for (int j = 0; j < 30; j++) begin cyc(0, 0, 0, 0); if (tc4 || tc1) flag_seen = 1; end
        chk("e_no_pulse", flag_seen, 0);

        // randomized traffic against the model
        do_reset();
        for (int j = 0; j < 400; j++) begin
            r_ld = ($urandom_range(0, 15) == 0);
            r_lv = $urandom_range(1, 12);
            r_st = ($urandom_range(0, 3) == 0);
            r_sp = !r_ld && ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            cyc(r_ld, r_lv, r_st, r_sp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
